// File: rtl/univ_shift_reg.sv
// Universal shift register: manual shift/rotate/load/clear modes plus an auto serializer FSM.
// Latency: every output is registered, one edge after its inputs; auto serialize = load edge + WIDTH shift edges.
// Backpressure: en=0 freezes all state (done forced low); start is ignored while busy, with no queuing.
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   en               clock enable (holds state, never clears)
//   mode[2:0]        manual op: 000 hold, 001 shr, 010 shl, 011 ror, 100 rol, 101 asr, 110 load, 111 clear
//   new_bit, din     serial and parallel inputs
//   start            auto-serialize request, sampled only in IDLE
//   d_out            last bit shifted or rotated out
//   reg_bits         register contents
//   shift_cnt        shifts since the last load/clear, saturating at WIDTH
//   busy, done       serializer active / one-cycle completion pulse
//   parity_out       XOR-reduce of reg_bits (only when UNIV_SHIFT_PARITY_EN is defined)
// Optional macro: UNIV_SHIFT_PARITY_EN adds the parity_out port and its register.

module univ_shift_reg #(
  parameter int WIDTH    = 8,
  parameter bit AUTO_DIR = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic                       new_bit,
  input  logic [WIDTH-1:0]           din,
  input  logic                       start,
  output logic                       d_out,
  output logic [WIDTH-1:0]           reg_bits,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       busy,
`ifdef UNIV_SHIFT_PARITY_EN
  output logic                       done,
  output logic                       parity_out
`else
  output logic                       done
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_op;

  always_comb begin
    state_d  = state_q;
    reg_d    = reg_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_op = 1'b0;

    if (state_q == SHIFT) begin
      shift_op = 1'b1;
      if (AUTO_DIR) begin
        reg_d  = {reg_q[WIDTH-2:0], new_bit};
        dout_d = reg_q[WIDTH-1];
      end else begin
        reg_d  = {new_bit, reg_q[WIDTH-1:1]};
        dout_d = reg_q[0];
      end
      // Counter was zeroed at load, so this is the WIDTH-th shift.
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      reg_d   = din;
      dout_d  = 1'b0;
      cnt_d   = '0;
      state_d = SHIFT;
    end else begin
      unique case (mode)
        3'b000: ;
        3'b001: begin
          reg_d    = {new_bit, reg_q[WIDTH-1:1]};
          dout_d   = reg_q[0];
          shift_op = 1'b1;
        end
        3'b010: begin
          reg_d    = {reg_q[WIDTH-2:0], new_bit};
          dout_d   = reg_q[WIDTH-1];
          shift_op = 1'b1;
        end
        3'b011: begin
          reg_d    = {reg_q[0], reg_q[WIDTH-1:1]};
          dout_d   = reg_q[0];
          shift_op = 1'b1;
        end
        3'b100: begin
          reg_d    = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
          dout_d   = reg_q[WIDTH-1];
          shift_op = 1'b1;
        end
        3'b101: begin
          reg_d    = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
          dout_d   = reg_q[0];
          shift_op = 1'b1;
        end
        3'b110: begin
          reg_d  = din;
          dout_d = 1'b0;
          cnt_d  = '0;
        end
        default: begin
          reg_d  = '0;
          dout_d = 1'b0;
          cnt_d  = '0;
        end
      endcase
    end

    // Saturating count: sticks at WIDTH instead of wrapping.
    if (shift_op && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      reg_q   <= '0;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      reg_q   <= reg_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end else begin
      // Stall: everything holds except the done pulse, which must not stretch.
      done_q <= 1'b0;
    end
  end

`ifdef UNIV_SHIFT_PARITY_EN
  logic parity_q;

  // Parity of the value being written, so it always tracks reg_bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (en) begin
      parity_q <= ^reg_d;
    end
  end

  assign parity_out = parity_q;
`endif

  assign d_out     = dout_q;
  assign reg_bits  = reg_q;
  assign shift_cnt = cnt_q;
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       new_bit;
  logic [7:0] din;
  logic       start;
  logic       d_out;
  logic [7:0] reg_bits;
  logic [3:0] shift_cnt;
  logic       busy;
  logic       done;
`ifdef UNIV_SHIFT_PARITY_EN
  logic       parity_out;
`endif

  int total = 0;
  int bad   = 0;

  univ_shift_reg #(.WIDTH(8), .AUTO_DIR(1'b0)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .new_bit   (new_bit),
    .din       (din),
    .start     (start),
    .d_out     (d_out),
    .reg_bits  (reg_bits),
    .shift_cnt (shift_cnt),
    .busy      (busy),
`ifdef UNIV_SHIFT_PARITY_EN
    .done      (done),
    .parity_out(parity_out)
`else
    .done      (done)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; mode = 3'b110; new_bit = 1'b1; din = 8'hFF; start = 1'b0;
    tick();
    tick();
    total++; if (reg_bits !== 8'h00) begin bad++; $display("FAIL reset_reg got=%h exp=00", reg_bits); end
    total++; if (d_out !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b exp=0", d_out); end
    total++; if (shift_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", shift_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef UNIV_SHIFT_PARITY_EN
    total++; if (parity_out !== 1'b0) begin bad++; $display("FAIL reset_parity got=%b exp=0", parity_out); end
`endif
    reset = 1'b0; mode = 3'b000; new_bit = 1'b0;
  endtask

  task automatic test_reset_mid_serialize();
    din = 8'hA5; start = 1'b1; mode = 3'b000; new_bit = 1'b0;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rms_busy_load got=%b exp=1", busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rms_done_shift%0d got=%b exp=0", i, done); end
    end
    total++; if (shift_cnt !== 4'd3) begin bad++; $display("FAIL rms_cnt_pre got=%0d exp=3", shift_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (reg_bits !== 8'h00) begin bad++; $display("FAIL rms_reg got=%h exp=00", reg_bits); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rms_busy got=%b exp=0", busy); end
    total++; if (shift_cnt !== 4'd0) begin bad++; $display("FAIL rms_cnt got=%0d exp=0", shift_cnt); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rms_done got=%b exp=0", done); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rms_done_after got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rms_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_auto_serialize();
    logic [7:0] seqv;
    logic [7:0] expr;
    seqv = 8'hB4;
    expr = 8'hB4;
    // clear mode on the input must be ignored on the load edge and while shifting
    din = 8'hB4; start = 1'b1; new_bit = 1'b0; mode = 3'b111;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL auto_busy_load got=%b exp=1", busy); end
    total++; if (reg_bits !== 8'hB4) begin bad++; $display("FAIL auto_reg_load got=%h exp=b4", reg_bits); end
    total++; if (shift_cnt !== 4'd0) begin bad++; $display("FAIL auto_cnt_load got=%0d exp=0", shift_cnt); end
    total++; if (d_out !== 1'b0) begin bad++; $display("FAIL auto_dout_load got=%b exp=0", d_out); end
    for (int i = 0; i < 8; i++) begin
      start = (i == 3);
      din   = 8'h5A;
      tick();
      expr = expr >> 1;
      total++; if (d_out !== seqv[i]) begin bad++; $display("FAIL auto_dout%0d got=%b exp=%b", i, d_out, seqv[i]); end
      total++; if (reg_bits !== expr) begin bad++; $display("FAIL auto_reg%0d got=%h exp=%h", i, reg_bits, expr); end
      total++; if (shift_cnt !== 4'(i + 1)) begin bad++; $display("FAIL auto_cnt%0d got=%0d exp=%0d", i, shift_cnt, i + 1); end
      total++; if (done !== (i == 7)) begin bad++; $display("FAIL auto_done%0d got=%b exp=%b", i, done, (i == 7)); end
      total++; if (busy !== (i != 7)) begin bad++; $display("FAIL auto_busy%0d got=%b exp=%b", i, busy, (i != 7)); end
    end
    start = 1'b0; mode = 3'b000;
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL auto_done_pulse got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL auto_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_stall();
    logic [7:0] seqv;
    logic [7:0] expr;
    seqv = 8'hB4;
    expr = 8'hB4;
    din = 8'hB4; start = 1'b1; new_bit = 1'b0; mode = 3'b000;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      expr = expr >> 1;
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (reg_bits !== 8'h2D) begin bad++; $display("FAIL stall_reg%0d got=%h exp=2d", k, reg_bits); end
      total++; if (d_out !== 1'b0) begin bad++; $display("FAIL stall_dout%0d got=%b exp=0", k, d_out); end
      total++; if (shift_cnt !== 4'd2) begin bad++; $display("FAIL stall_cnt%0d got=%0d exp=2", k, shift_cnt); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy%0d got=%b exp=1", k, busy); end
    end
    en = 1'b1;
    for (int i = 2; i < 8; i++) begin
      tick();
      expr = expr >> 1;
      total++; if (d_out !== seqv[i]) begin bad++; $display("FAIL stall_dout_run%0d got=%b exp=%b", i, d_out, seqv[i]); end
      total++; if (reg_bits !== expr) begin bad++; $display("FAIL stall_reg_run%0d got=%h exp=%h", i, reg_bits, expr); end
      total++; if (done !== (i == 7)) begin bad++; $display("FAIL stall_done%0d got=%b exp=%b", i, done, (i == 7)); end
    end
    tick();
  endtask

  task automatic test_rotate_arith();
    din = 8'h81; mode = 3'b110;
    tick();
    total++; if (reg_bits !== 8'h81) begin bad++; $display("FAIL ra_load got=%h exp=81", reg_bits); end
    mode = 3'b011;
    tick();
    total++; if (reg_bits !== 8'hC0) begin bad++; $display("FAIL ra_ror_reg got=%h exp=c0", reg_bits); end
    total++; if (d_out !== 1'b1) begin bad++; $display("FAIL ra_ror_dout got=%b exp=1", d_out); end
    mode = 3'b101;
    tick();
    total++; if (reg_bits !== 8'hE0) begin bad++; $display("FAIL ra_asr_reg got=%h exp=e0", reg_bits); end
    total++; if (d_out !== 1'b0) begin bad++; $display("FAIL ra_asr_dout got=%b exp=0", d_out); end
    total++; if (shift_cnt !== 4'd2) begin bad++; $display("FAIL ra_cnt got=%0d exp=2", shift_cnt); end
    mode = 3'b000;
  endtask

  task automatic test_modes();
    din = 8'h3C; mode = 3'b110;
    tick();
    mode = 3'b001; new_bit = 1'b1;
    tick();
    total++; if (reg_bits !== 8'h9E) begin bad++; $display("FAIL md_shr_reg got=%h exp=9e", reg_bits); end
    total++; if (d_out !== 1'b0) begin bad++; $display("FAIL md_shr_dout got=%b exp=0", d_out); end
    mode = 3'b010; new_bit = 1'b0;
    tick();
    total++; if (reg_bits !== 8'h3C) begin bad++; $display("FAIL md_shl_reg got=%h exp=3c", reg_bits); end
    total++; if (d_out !== 1'b1) begin bad++; $display("FAIL md_shl_dout got=%b exp=1", d_out); end
    mode = 3'b000; new_bit = 1'b1;
    tick();
    total++; if (reg_bits !== 8'h3C) begin bad++; $display("FAIL md_hold_reg got=%h exp=3c", reg_bits); end
    total++; if (d_out !== 1'b1) begin bad++; $display("FAIL md_hold_dout got=%b exp=1", d_out); end
    total++; if (shift_cnt !== 4'd2) begin bad++; $display("FAIL md_hold_cnt got=%0d exp=2", shift_cnt); end
    mode = 3'b100;
    tick();
    total++; if (reg_bits !== 8'h78) begin bad++; $display("FAIL md_rol_reg got=%h exp=78", reg_bits); end
    total++; if (d_out !== 1'b0) begin bad++; $display("FAIL md_rol_dout got=%b exp=0", d_out); end
    total++; if (shift_cnt !== 4'd3) begin bad++; $display("FAIL md_rol_cnt got=%0d exp=3", shift_cnt); end
    mode = 3'b000;
  endtask

  task automatic test_saturation_priority();
    din = 8'h01; mode = 3'b110;
    tick();
    mode = 3'b010; new_bit = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    total++; if (shift_cnt !== 4'd8) begin bad++; $display("FAIL sat_cnt got=%0d exp=8", shift_cnt); end
    total++; if (reg_bits !== 8'hFF) begin bad++; $display("FAIL sat_reg got=%h exp=ff", reg_bits); end
    total++; if (d_out !== 1'b1) begin bad++; $display("FAIL sat_dout got=%b exp=1", d_out); end
    mode = 3'b111; en = 1'b0;
    tick();
    total++; if (reg_bits !== 8'hFF) begin bad++; $display("FAIL pri_en0_reg got=%h exp=ff", reg_bits); end
    total++; if (shift_cnt !== 4'd8) begin bad++; $display("FAIL pri_en0_cnt got=%0d exp=8", shift_cnt); end
    total++; if (d_out !== 1'b1) begin bad++; $display("FAIL pri_en0_dout got=%b exp=1", d_out); end
    en = 1'b1;
    tick();
    total++; if (reg_bits !== 8'h00) begin bad++; $display("FAIL pri_clr_reg got=%h exp=00", reg_bits); end
    total++; if (shift_cnt !== 4'd0) begin bad++; $display("FAIL pri_clr_cnt got=%0d exp=0", shift_cnt); end
    total++; if (d_out !== 1'b0) begin bad++; $display("FAIL pri_clr_dout got=%b exp=0", d_out); end
    mode = 3'b000;
  endtask

`ifdef UNIV_SHIFT_PARITY_EN
  task automatic test_parity();
    din = 8'h07; mode = 3'b110;
    tick();
    total++; if (parity_out !== 1'b1) begin bad++; $display("FAIL par_load got=%b exp=1", parity_out); end
    mode = 3'b010; new_bit = 1'b1;
    tick();
    total++; if (reg_bits !== 8'h0F) begin bad++; $display("FAIL par_reg got=%h exp=0f", reg_bits); end
    total++; if (parity_out !== 1'b0) begin bad++; $display("FAIL par_shl got=%b exp=0", parity_out); end
    mode = 3'b000;
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_serialize();
    test_auto_serialize();
    test_stall();
    test_rotate_arith();
    test_modes();
    test_saturation_priority();
`ifdef UNIV_SHIFT_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the team's 4-bit right/left shift register.
- Adds configurable width, eight manual operating modes, a saturating shift counter, and an automatic serializer with a busy/done handshake.
- Sits between parallel datapath registers and single-wire serial links.
- Serves as both a serializer (parallel in, serial out) and a deserializer (serial in, parallel out).

Parameters:
- WIDTH, 8: register width in bits; minimum 2.
- AUTO_DIR, 0: auto-serialize direction. 0 = shift right, LSB out first, new_bit enters at the MSB. 1 = shift left, MSB out first, new_bit enters at the LSB.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  clock enable. 0 = all state holds; it does not clear.
- mode  in  3  manual operation select (see Behaviour).
- new_bit  in  1  serial input bit.
- din  in  WIDTH  parallel load data.
- start  in  1  auto-serialize request, sampled only in IDLE.
- d_out  out  1  registered serial output: the last bit shifted or rotated out.
- reg_bits  out  WIDTH  register contents.
- shift_cnt  out  $clog2(WIDTH+1)  shift/rotate operations since the last load/clear; saturates at WIDTH.
- busy  out  1  high while the FSM is in SHIFT.
- done  out  1  one-cycle pulse at the end of an auto-serialize.

Behaviour:
- Interface (decided): one clock, clock. Reset is synchronous and active-high, port name reset.
- Reset: evaluated only on a rising clock edge. Values after reset:
  - reg_bits = 0, d_out = 0, shift_cnt = 0, busy = 0, done = 0.
  - FSM = IDLE.
  - Reset overrides everything, including mid-serialize; no done pulse is emitted.
- Priority per edge: reset > en==0 (hold all; done forced 0) > FSM SHIFT > start in IDLE > manual mode.
- FSM has two states:
  - IDLE: manual mode applies.
  - SHIFT: mode is ignored.
- IDLE with start=1 and en=1:
  - reg_bits <= din; d_out <= 0; shift_cnt <= 0; go to SHIFT.
  - The mode input is ignored that cycle.
- SHIFT, each enabled cycle:
  - Perform one shift in the AUTO_DIR direction, shifting in new_bit.
  - d_out <= the exiting bit; shift_cnt increments.
- Leaving SHIFT:
  - On the edge where shift_cnt goes WIDTH-1 -> WIDTH: done = 1 for one cycle, go to IDLE, busy drops the same edge.
  - Serializer latency: load edge plus WIDTH shift edges.
  - start during SHIFT is ignored; no queuing.
- en=0 during SHIFT stalls the FSM without corrupting state.
- Manual modes (IDLE only):
  - 000 hold: nothing changes.
  - 001 shift right: reg <= {new_bit, reg[W-1:1]}; d_out <= reg[0].
  - 010 shift left: reg <= {reg[W-2:0], new_bit}; d_out <= reg[W-1].
  - 011 rotate right: reg <= {reg[0], reg[W-1:1]}; d_out <= reg[0].
  - 100 rotate left: reg <= {reg[W-2:0], reg[W-1]}; d_out <= reg[W-1].
  - 101 arithmetic shift right: reg <= {reg[W-1], reg[W-1:1]}; d_out <= reg[0].
  - 110 parallel load: reg <= din; d_out <= 0; shift_cnt <= 0.
  - 111 clear: reg <= 0; d_out <= 0; shift_cnt <= 0.
- shift_cnt:
  - Increments on every shift/rotate/arith operation, manual or auto.
  - Saturates at WIDTH; never wraps.
  - Unchanged on hold.
- d_out holds its value on hold and when en=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: UNIV_SHIFT_PARITY_EN.
- Defined:
  - Adds output port parity_out (out, 1): registered even parity (XOR-reduce) of the reg_bits value being written each edge, so it always matches the current reg_bits.
  - parity_out resets to 0 and holds when en=0.
- Undefined: port absent; no parity logic.

Test Plan:
- Reset mid-serialize:
  - WIDTH=8; start with din=8'hA5; assert reset after 3 shifts.
  - Next edge: reg_bits=0, busy=0, shift_cnt=0; done never pulses.
- Auto serialize, AUTO_DIR=0:
  - din=8'hB4, new_bit=0, start pulse.
  - d_out sequence over 8 shift edges: 0,0,1,0,1,1,0,1.
  - done pulses on edge 9 after the load edge; reg_bits=0; busy low the same edge.
- Stall:
  - During auto shift of 8'hB4, hold en=0 for 3 cycles after the 2nd shift.
  - reg_bits, d_out and shift_cnt are frozen; done still arrives after exactly 8 enabled shift edges.
- Manual rotate and arith:
  - Load 8'h81. Rotate right once: reg_bits=8'hC0, d_out=1.
  - Then arith shift right: reg_bits=8'hE0, d_out=0, shift_cnt=2.
- Saturation and priority:
  - Load 8'h01; shift left 10 times with new_bit=1: shift_cnt=8 (not wrapped), reg_bits=8'hFF.
  - Then mode=111 together with en=0: no change.
  - Then en=1: reg_bits=0, shift_cnt=0.
- Parity (with UNIV_SHIFT_PARITY_EN):
  - Load 8'h07: parity_out=1.
  - Shift left with new_bit=1: reg_bits=8'h0F, parity_out=0.
